// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared board dimensions, lock-sequencer state type and
//               line-counter width for the playfield logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

  // Default board geometry; y = 0 is the top row
  localparam int DEF_FIXED_STATE_WIDTH  = 10;
  localparam int DEF_FIXED_STATE_HEIGHT = 20;
  localparam int DEF_GRID               = 4;
  localparam int DEF_LOCK_TICKS         = 2;

  // Width of the saturating cleared-lines total
  localparam int LINES_W = 16;

  typedef enum logic [2:0] {
    S_SPAWN = 3'd0,
    S_FALL  = 3'd1,
    S_LOCK  = 3'd2,
    S_SCAN  = 3'd3,
    S_SHIFT = 3'd4,
    S_OVER  = 3'd5
  } lock_state_t;

endpackage

`default_nettype wire

// File: rtl/row_full_check.sv
// ============================================================================
// Module      : row_full_check
// Description : Combinational test of whether one board row is occupied in
//               every column.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_full_check
  import game_pkg::*;
#(
  parameter int WIDTH  = DEF_FIXED_STATE_WIDTH,
  parameter int HEIGHT = DEF_FIXED_STATE_HEIGHT
) (
  input  logic [WIDTH-1:0][HEIGHT-1:0]  screen,
  input  logic [$clog2(HEIGHT)-1:0]     row,
  output logic                          full
);

  logic [WIDTH-1:0] row_bits;

  // Gather the selected row across all columns
  for (genvar x = 0; x < WIDTH; x++) begin : g_col
    assign row_bits[x] = screen[x][row];
  end

  assign full = &row_bits;

endmodule

`default_nettype wire

// File: rtl/piece_lock_controller.sv
// ============================================================================
// Module      : piece_lock_controller
// Description : Gravity/lock sequencer owning the fixed playfield. Issues drop
//               pulses, merges a landed piece, clears full rows bottom-up and
//               requests the next spawn.
//               Optional macro LOCK_DELAY_EN adds a lock-grace tick counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piece_lock_controller
  import game_pkg::*;
#(
  parameter int FIXED_STATE_WIDTH  = DEF_FIXED_STATE_WIDTH,
  parameter int FIXED_STATE_HEIGHT = DEF_FIXED_STATE_HEIGHT,
  parameter int GRID               = DEF_GRID,
  parameter int LOCK_TICKS         = DEF_LOCK_TICKS
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              gravity_tick,
  input  logic                                              active_piece_toutching,
  input  logic                                              no_piece,
  input  logic [GRID-1:0][GRID-1:0]                         active_piece_grid_piece,
  input  logic [$clog2(FIXED_STATE_WIDTH)-1:0]              piece_x,
  input  logic [$clog2(FIXED_STATE_HEIGHT)-1:0]             piece_y,
  input  logic                                              spawn_ack,
  output logic [FIXED_STATE_WIDTH-1:0][FIXED_STATE_HEIGHT-1:0] GAME_fixed_state_screen,
  output logic                                              drop_pulse,
  output logic                                              spawn_req,
  output logic                                              piece_locked,
  output logic [LINES_W-1:0]                                lines_cleared,
  output logic                                              game_over
);

  localparam int W     = FIXED_STATE_WIDTH;
  localparam int H     = FIXED_STATE_HEIGHT;
  localparam int Y_W   = $clog2(H);
  localparam int EXT_W = H + GRID;
  localparam int SH_W  = H + 1;

  lock_state_t               state_q, state_d;
  logic [W-1:0][H-1:0]       screen_q, screen_d;
  logic [Y_W-1:0]            scan_y_q, scan_y_d;
  logic                      drop_pulse_q, drop_pulse_d;
  logic                      spawn_req_q, spawn_req_d;
  logic                      piece_locked_q, piece_locked_d;
  logic [LINES_W-1:0]        lines_q, lines_d;
  logic                      game_over_q, game_over_d;

  logic                      tick_live;
  logic                      spawn_accept;
  logic                      lock_expired;
  logic                      row_full;
  logic                      top_row_used;
  logic [W-1:0][H-1:0]       merge_mask;
  logic [W-1:0][H-1:0]       shifted;
  logic [H-1:0]              low_mask;

  // A gravity tick only counts while a piece is actually on the board
  assign tick_live    = gravity_tick && !no_piece;
  assign spawn_accept = (state_q == S_SPAWN) && spawn_req_q && spawn_ack;

  row_full_check #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) u_row_full (
    .screen (screen_q),
    .row    (scan_y_q),
    .full   (row_full)
  );

`ifdef LOCK_DELAY_EN
  localparam int CNT_W = (LOCK_TICKS < 1) ? 1 : $clog2(LOCK_TICKS + 1);

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  // Grace counter: reloaded on free falls and on spawn, spent by touching ticks
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (spawn_accept) begin
      lock_cnt_d = CNT_W'(LOCK_TICKS);
    end else if ((state_q == S_FALL) && tick_live) begin
      if (!active_piece_toutching) begin
        lock_cnt_d = CNT_W'(LOCK_TICKS);
      end else if (lock_cnt_q != '0) begin
        lock_cnt_d = lock_cnt_q - 1'b1;
      end
    end
  end

  // Grace counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q <= CNT_W'(LOCK_TICKS);
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign lock_expired = (lock_cnt_q == '0);
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = (LOCK_TICKS > 0);
  assign lock_expired    = 1'b1;
`endif

  // Board image of the active piece; cells beyond the right or bottom edge drop out
  always_comb begin
    merge_mask = '0;
    for (int cx = 0; cx < W; cx++) begin
      for (int px = 0; px < GRID; px++) begin
        if (int'(piece_x) + px == cx) begin
          merge_mask[cx] = merge_mask[cx] |
                           H'(EXT_W'(active_piece_grid_piece[px]) << piece_y);
        end
      end
    end
  end

  // Board with the scan row removed: rows [y:1] take rows [y-1:0], row 0 empties
  always_comb begin
    low_mask = H'((SH_W'(2) << scan_y_q) - SH_W'(1));
    for (int cx = 0; cx < W; cx++) begin
      shifted[cx] = (screen_q[cx] & ~low_mask) |
                    ({screen_q[cx][H-2:0], 1'b0} & low_mask);
    end
  end

  // Any occupied cell in the top row ends the game once scanning finishes
  always_comb begin
    top_row_used = 1'b0;
    for (int cx = 0; cx < W; cx++) begin
      top_row_used = top_row_used | screen_q[cx][0];
    end
  end

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    screen_d       = screen_q;
    scan_y_d       = scan_y_q;
    lines_d        = lines_q;
    drop_pulse_d   = 1'b0;
    piece_locked_d = 1'b0;

    case (state_q)
      S_SPAWN: begin
        if (spawn_accept) begin
          state_d = S_FALL;
        end
      end
      S_FALL: begin
        if (tick_live) begin
          if (!active_piece_toutching) begin
            drop_pulse_d = 1'b1;
          end else if (lock_expired) begin
            state_d = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        screen_d       = screen_q | merge_mask;
        piece_locked_d = 1'b1;
        scan_y_d       = Y_W'(H - 1);
        state_d        = S_SCAN;
      end
      S_SCAN: begin
        if (row_full) begin
          state_d = S_SHIFT;
        end else if (scan_y_q == '0) begin
          state_d = top_row_used ? S_OVER : S_SPAWN;
        end else begin
          scan_y_d = scan_y_q - 1'b1;
        end
      end
      S_SHIFT: begin
        screen_d = shifted;
        if (lines_q != {LINES_W{1'b1}}) begin
          lines_d = lines_q + 1'b1;
        end
        // Same row is rescanned: whatever dropped into it may also be full
        state_d = S_SCAN;
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_SPAWN;
      end
    endcase

    spawn_req_d = (state_d == S_SPAWN);
    game_over_d = game_over_q || (state_d == S_OVER);
  end

  // Sequencer state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_SPAWN;
      screen_q       <= '0;
      scan_y_q       <= '0;
      drop_pulse_q   <= 1'b0;
      spawn_req_q    <= 1'b0;
      piece_locked_q <= 1'b0;
      lines_q        <= '0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      screen_q       <= screen_d;
      scan_y_q       <= scan_y_d;
      drop_pulse_q   <= drop_pulse_d;
      spawn_req_q    <= spawn_req_d;
      piece_locked_q <= piece_locked_d;
      lines_q        <= lines_d;
      game_over_q    <= game_over_d;
    end
  end

  assign GAME_fixed_state_screen = screen_q;
  assign drop_pulse              = drop_pulse_q;
  assign spawn_req               = spawn_req_q;
  assign piece_locked            = piece_locked_q;
  assign lines_cleared           = lines_q;
  assign game_over               = game_over_q;

endmodule

`default_nettype wire
